// File: rtl/control32_multicycle_if.sv
// Memory/IO side of the multicycle controller.
// The controller drives the access strobes and samples the ready lines.
interface control32_multicycle_if #(
  parameter int ADDR_HIGH_W = 22
);
  logic [ADDR_HIGH_W-1:0] Alu_resultHigh;
  logic                   mem_ready;
  logic                   io_ready;
  logic                   MemRead;
  logic                   MemWrite;
  logic                   IORead;
  logic                   IOWrite;

  modport master (
    input  Alu_resultHigh,
    input  mem_ready,
    input  io_ready,
    output MemRead,
    output MemWrite,
    output IORead,
    output IOWrite
  );

  modport slave (
    output Alu_resultHigh,
    output mem_ready,
    output io_ready,
    input  MemRead,
    input  MemWrite,
    input  IORead,
    input  IOWrite
  );
endinterface

// File: rtl/control32_multicycle.sv
// Multicycle MIPS-style control unit: FETCH/DECODE/EXEC/MEM/WB
// sequencing with memory/IO wait states and a bus-error timeout.
module control32_multicycle #(
  parameter int                     ADDR_HIGH_W   = 22,
  parameter logic [ADDR_HIGH_W-1:0] IO_HIGH_VALUE = '1,
  parameter int                     WAIT_LIMIT    = 15
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [5:0] Opcode,
  input  logic [5:0] Function_opcode,
  control32_multicycle_if.master bus,
  output logic [2:0] state,
  output logic       PCWrite,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic       RegDST,
  output logic       ALUSrc,
  output logic       MemorIOtoReg,
  output logic       I_format,
  output logic       Sftmd,
  output logic       Jrn,
  output logic       Branch,
  output logic       nBranch,
  output logic       Jmp,
  output logic       Jal,
  output logic [1:0] ALUOp,
  output logic       bus_err,
  output logic       illegal
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4
  } state_t;

  localparam logic [7:0] WL = 8'(WAIT_LIMIT);

  state_t     state_q;
  state_t     state_d;
  logic [5:0] op_q;
  logic [5:0] fn_q;
  logic [7:0] wait_q;

  logic r_type;
  logic is_lw;
  logic is_sw;
  logic is_beq;
  logic is_bne;
  logic is_j;
  logic is_jal;
  logic is_jr;
  logic legal;
  logic io_sel;
  logic sel_ready;
  logic timeout;

  logic mem_rd;
  logic mem_wr;
  logic io_rd;
  logic io_wr;

  assign r_type = (op_q == 6'b000000);
  assign is_lw  = (op_q == 6'b100011);
  assign is_sw  = (op_q == 6'b101011);
  assign is_beq = (op_q == 6'b000100);
  assign is_bne = (op_q == 6'b000101);
  assign is_j   = (op_q == 6'b000010);
  assign is_jal = (op_q == 6'b000011);
  assign is_jr  = r_type && (fn_q == 6'b001000);

  assign I_format     = (op_q[5:3] == 3'b001);
  assign RegDST       = r_type;
  assign ALUSrc       = I_format | is_lw | is_sw;
  assign MemorIOtoReg = is_lw;
  assign Jrn          = is_jr;
  assign Sftmd        = r_type && (fn_q[5:3] == 3'b000);
  assign ALUOp        = {r_type | I_format, is_beq | is_bne};

  assign legal = r_type | I_format | is_lw | is_sw
               | is_beq | is_bne | is_j | is_jal;

  // Only the ready line of the addressed space may end a MEM access.
  assign io_sel    = (bus.Alu_resultHigh == IO_HIGH_VALUE);
  assign sel_ready = io_sel ? bus.io_ready : bus.mem_ready;
  assign timeout   = (wait_q >= WL);

  assign state = state_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= S_FETCH;
      op_q    <= '0;
      fn_q    <= '0;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      if (IRWrite) begin
        op_q <= Opcode;
        fn_q <= Function_opcode;
      end
      if (state_q != S_MEM) begin
        wait_q <= '0;
      end else if (!timeout) begin
        wait_q <= wait_q + 8'd1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_FETCH: begin
        if (bus.mem_ready) state_d = S_DECODE;
      end
      S_DECODE: begin
        state_d = legal ? S_EXEC : S_FETCH;
      end
      S_EXEC: begin
        unique case (1'b1)
          is_lw | is_sw:
            state_d = S_MEM;
          (r_type & ~is_jr) | I_format | is_jal:
            state_d = S_WB;
          default:
            state_d = S_FETCH;
        endcase
      end
      S_MEM: begin
        if (timeout) begin
          state_d = S_FETCH;
        end else if (sel_ready) begin
          state_d = is_lw ? S_WB : S_FETCH;
        end
      end
      S_WB: begin
        state_d = S_FETCH;
      end
      default: begin
        state_d = S_FETCH;
      end
    endcase
  end

  // Strobes are gated by reset so an access drops the instant reset falls.
  always_comb begin
    PCWrite  = 1'b0;
    IRWrite  = 1'b0;
    RegWrite = 1'b0;
    Branch   = 1'b0;
    nBranch  = 1'b0;
    Jmp      = 1'b0;
    Jal      = 1'b0;
    bus_err  = 1'b0;
    illegal  = 1'b0;
    mem_rd   = 1'b0;
    mem_wr   = 1'b0;
    io_rd    = 1'b0;
    io_wr    = 1'b0;
    if (reset) begin
      unique case (state_q)
        S_FETCH: begin
          mem_rd  = 1'b1;
          IRWrite = bus.mem_ready;
          PCWrite = bus.mem_ready;
        end
        S_DECODE: begin
          illegal = ~legal;
        end
        S_EXEC: begin
          Branch  = is_beq;
          nBranch = is_bne;
          Jmp     = is_j;
          Jal     = is_jal;
          PCWrite = is_j | is_jal | is_jr
                  | is_beq | is_bne;
        end
        S_MEM: begin
          if (timeout) begin
            bus_err = 1'b1;
          end else begin
            mem_rd = is_lw & ~io_sel;
            io_rd  = is_lw &  io_sel;
            mem_wr = is_sw & ~io_sel;
            io_wr  = is_sw &  io_sel;
          end
        end
        S_WB: begin
          RegWrite = 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.MemRead  = mem_rd;
  assign bus.MemWrite = mem_wr;
  assign bus.IORead   = io_rd;
  assign bus.IOWrite  = io_wr;

endmodule
